// File: rtl/mux_nto1_arb.sv
// ----------------------------------------------------------------------------
// mux_nto1_arb
//   N-to-1 data selector with per-channel valid/ready handshake and a single
//   registered output stage. MODE 0 steers by select_i; MODE 1 arbitrates
//   round-robin among requesting channels. The output word is held under
//   back-pressure.
//
// Ports
//   clk_i     in   1         clock, rising edge
//   rst_i     in   1         synchronous reset, active-high
//   data_i    in   CH*WIDTH  channel k data at data_i[k*WIDTH +: WIDTH]
//   valid_i   in   CH        channel k offers data
//   ready_o   out  CH        channel k transfer accepted this cycle (one-hot/0)
//   select_i  in   SEL_W     channel to take in MODE 0; ignored in MODE 1
//   data_o    out  WIDTH     registered output data
//   valid_o   out  1         data_o holds a valid word
//   ready_i   in   1         consumer accepts data_o this cycle
//   grant_o   out  SEL_W     registered index of the channel behind data_o
// ----------------------------------------------------------------------------
module mux_nto1_arb #(
    parameter int WIDTH = 32,
    parameter int CH    = 4,
    parameter int SEL_W = 2,
    parameter int MODE  = 0
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [CH*WIDTH-1:0] data_i,
    input  logic [CH-1:0]       valid_i,
    output logic [CH-1:0]       ready_o,
    input  logic [SEL_W-1:0]    select_i,
    output logic [WIDTH-1:0]    data_o,
    output logic                valid_o,
    input  logic                ready_i,
    output logic [SEL_W-1:0]    grant_o
);

    localparam int unsigned CHU = CH;

    logic [WIDTH-1:0] data_q;
    logic             valid_q;
    logic [SEL_W-1:0] grant_q;
    logic [SEL_W-1:0] last_q;

    logic             load;
    logic             found;
    logic [SEL_W-1:0] win;
    logic [WIDTH-1:0] data_sel;

    always_comb begin
        int unsigned idx;
        idx      = 0;
        load     = (!valid_q || ready_i) && !rst_i;
        found    = 1'b0;
        win      = '0;
        data_sel = '0;
        ready_o  = '0;

        if (MODE == 0) begin
            // An out-of-range select_i matches no channel, so it yields no winner.
            for (int unsigned k = 0; k < CHU; k++) begin
                if ((SEL_W'(k) == select_i) && valid_i[k]) begin
                    found = 1'b1;
                    win   = SEL_W'(k);
                end
            end
        end else begin
            // Scan last+1 .. last+CH; the sum stays below 2*CH, so one
            // conditional subtract replaces the modulo.
            for (int unsigned i = 1; i <= CHU; i++) begin
                idx = 32'(last_q) + i;
                if (idx >= CHU) idx = idx - CHU;
                if (!found && valid_i[idx]) begin
                    found = 1'b1;
                    win   = SEL_W'(idx);
                end
            end
        end

        for (int unsigned k = 0; k < CHU; k++) begin
            if (SEL_W'(k) == win) data_sel = data_i[k*WIDTH +: WIDTH];
            ready_o[k] = load && found && (SEL_W'(k) == win);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            grant_q <= '0;
            last_q  <= SEL_W'(CH - 1);
        end else if (load) begin
            if (found) begin
                data_q  <= data_sel;
                valid_q <= 1'b1;
                grant_q <= win;
                if (MODE != 0) last_q <= win;
            end else begin
                valid_q <= 1'b0;
            end
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign grant_o = grant_q;

endmodule

// File: tb/tb_mux_nto1_arb.sv
// ----------------------------------------------------------------------------
// tb_mux_nto1_arb
//   Drives one MODE 0 and one MODE 1 instance (WIDTH=8, CH=4) from shared
//   data/valid/ready inputs and compares both against a behavioural model.
// ----------------------------------------------------------------------------
module tb_mux_nto1_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] din;
    logic [3:0]  vin;
    logic [1:0]  sel;
    logic        rdy;

    logic [3:0]  rdy_o0, rdy_o1;
    logic [7:0]  d_o0, d_o1;
    logic        v_o0, v_o1;
    logic [1:0]  g_o0, g_o1;

    int n_chk  = 0;
    int n_fail = 0;

    // model state per mode
    int m_data [2];
    int m_valid[2];
    int m_grant[2];
    int m_last [2];
    int exp_rdy[2];

    always #5 clk = ~clk;

    mux_nto1_arb #(.WIDTH(8), .CH(4), .SEL_W(2), .MODE(0)) u_m0 (
        .clk_i(clk), .rst_i(rst), .data_i(din), .valid_i(vin), .ready_o(rdy_o0),
        .select_i(sel), .data_o(d_o0), .valid_o(v_o0), .ready_i(rdy), .grant_o(g_o0)
    );

    mux_nto1_arb #(.WIDTH(8), .CH(4), .SEL_W(2), .MODE(1)) u_m1 (
        .clk_i(clk), .rst_i(rst), .data_i(din), .valid_i(vin), .ready_o(rdy_o1),
        .select_i(sel), .data_o(d_o1), .valid_o(v_o1), .ready_i(rdy), .grant_o(g_o1)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winning channel under the selection rules, -1 when there is none.
    function automatic int winner(input int mode, input logic [3:0] v,
                                  input int s, input int last);
        if (mode == 0) return (s < 4 && v[s]) ? s : -1;
        for (int off = 1; off <= 4; off++) begin
            int k;
            k = (last + off) % 4;
            if (v[k]) return k;
        end
        return -1;
    endfunction

    // One clock: check ready_o before the edge, advance model, check outputs.
    task automatic step();
        int w[2];
        bit ld;
        #1;
        for (int m = 0; m < 2; m++) begin
            ld = (m_valid[m] == 0 || rdy) && !rst;
            w[m] = winner(m, vin, int'(sel), m_last[m]);
            exp_rdy[m] = (ld && w[m] >= 0) ? (1 << w[m]) : 0;
        end
        chk("ready_m0", int'(rdy_o0), exp_rdy[0]);
        chk("ready_m1", int'(rdy_o1), exp_rdy[1]);
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (rst) begin
                m_data[m] = 0; m_valid[m] = 0; m_grant[m] = 0; m_last[m] = 3;
            end else if (m_valid[m] == 0 || rdy) begin
                if (w[m] >= 0) begin
                    m_data[m]  = int'(din[w[m]*8 +: 8]);
                    m_valid[m] = 1;
                    m_grant[m] = w[m];
                    if (m == 1) m_last[m] = w[m];
                end else begin
                    m_valid[m] = 0;
                end
            end
        end
        @(negedge clk);
        chk("data_m0",  int'(d_o0), m_data[0]);
        chk("valid_m0", int'(v_o0), m_valid[0]);
        chk("grant_m0", int'(g_o0), m_grant[0]);
        chk("data_m1",  int'(d_o1), m_data[1]);
        chk("valid_m1", int'(v_o1), m_valid[1]);
        chk("grant_m1", int'(g_o1), m_grant[1]);
    endtask

    initial begin
        logic [3:0] pend;
        // reset
        rst = 1'b1; din = 32'h44332211; vin = 4'b1111; sel = 2'd2; rdy = 1'b1;
        step();
        chk("rst_valid", int'(v_o1), 0);
        chk("rst_ready", int'(rdy_o0 | rdy_o1), 0);
        rst = 1'b0;

        // test 1: steered select of channel 2
        step();
        chk("t1_ready", exp_rdy[0], 4'b0100);
        chk("t1_data", int'(d_o0), 8'h33);
        chk("t1_grant", int'(g_o0), 2);

        // test 2: selected channel not valid -> valid falls, data holds
        sel = 2'd3; vin = 4'b0111;
        step();
        chk("t2_ready", int'(rdy_o0), 0);
        chk("t2_valid", int'(v_o0), 0);
        chk("t2_hold", int'(d_o0), 8'h33);

        // test 3: all channels valid -> rotating grants from ch0
        rst = 1'b1; step(); rst = 1'b0;
        din = 32'h44332211; vin = 4'b1111; rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t3_seq", int'(g_o1), i % 4);
            chk("t3_valid", int'(v_o1), 1);
        end

        // test 4: stall holds data and ready stays low, release grants ch1
        din = 32'h000000AA; vin = 4'b0001;
        step();
        chk("t4_load", int'(d_o1), 8'hAA);
        din = 32'h00BBCC00; vin = 4'b0110; rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_stall_rdy", int'(rdy_o1), 0);
            chk("t4_stall_data", int'(d_o1), 8'hAA);
        end
        rdy = 1'b1;
        step();
        chk("t4_rel_rdy", exp_rdy[1], 4'b0010);
        chk("t4_rel_data", int'(d_o1), 8'hCC);

        // test 5: last=3, ch0 and ch3 requesting -> 0,3,0
        din = 32'h40302010; vin = 4'b1000;
        step();
        chk("t5_last3", int'(g_o1), 3);
        vin = 4'b1001;
        step(); chk("t5_g0", int'(g_o1), 0);
        step(); chk("t5_g3", int'(g_o1), 3);
        step(); chk("t5_g0b", int'(g_o1), 0);

        // test 6: reset while output valid
        vin = 4'b1111;
        rst = 1'b1;
        step();
        chk("t6_valid", int'(v_o1), 0);
        chk("t6_data", int'(d_o1), 0);
        chk("t6_grant", int'(g_o1), 0);
        rst = 1'b0;
        step();
        chk("t6_first", int'(g_o1), 0);

        // random: MODE 0 style, unconstrained inputs
        for (int i = 0; i < 60; i++) begin
            din = $urandom; vin = 4'($urandom); sel = 2'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            step();
        end

        // random: producers hold valid/data until accepted by the arbiter
        pend = 4'b0000;
        for (int i = 0; i < 120; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (!pend[k] && $urandom_range(0, 1) == 1) begin
                    pend[k] = 1'b1;
                    din[k*8 +: 8] = 8'($urandom);
                end
            end
            vin = pend; sel = 2'($urandom);
            rdy = ($urandom_range(0, 3) != 0);
            step();
            pend = pend & ~4'(exp_rdy[1]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
